// File: rtl/dmem_arbiter.sv
// Data-memory arbiter. The processor always has priority on the shared single-port RAM.
// The secondary requester (display/game logic) is served whenever the processor leaves the RAM free.
// A debounced push-button is memory-mapped at BUTTON_ADDR.
module dmem_arbiter #(
    parameter logic [31:0] BUTTON_ADDR     = 32'd1000,
    parameter int          DEBOUNCE_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    // processor dmem request
    input  logic        proc_wren,
    input  logic        proc_rd,
    input  logic [31:0] proc_addr,
    input  logic [31:0] proc_data,
    output logic [31:0] proc_q,
    // secondary requester
    input  logic        aux_req,
    input  logic        aux_wren,
    input  logic [11:0] aux_addr,
    input  logic [31:0] aux_data,
    output logic        aux_gnt,
    output logic        aux_valid,
    output logic [31:0] aux_q,
    // raw asynchronous button
    input  logic        button_in,
    // single-port RAM, 1-cycle synchronous read
    output logic        ram_wEn,
    output logic [11:0] ram_addr,
    output logic [31:0] ram_dataIn,
    input  logic [31:0] ram_dataOut
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_AUX_RD = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic               btn_rd_q, btn_rd_d;
    logic               btn_val_q;
    logic               sync1_q, sync2_q;
    logic               btn_db_q, btn_db_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               proc_acc_s;
    logic               btn_acc_s;
    logic               proc_ram_s;
    logic               aux_gnt_s;
    logic               aux_valid_s;

    // A button access never touches the RAM, so only non-button processor accesses occupy it.
    assign proc_acc_s = proc_wren | proc_rd;
    assign btn_acc_s  = proc_acc_s && (proc_addr == BUTTON_ADDR);
    assign proc_ram_s = proc_acc_s && !btn_acc_s;

    // Arbitration FSM: grants aux when the RAM is free, and tracks the aux read-data cycle.
    always_comb begin
        state_d     = state_q;
        aux_gnt_s   = 1'b0;
        aux_valid_s = 1'b0;
        if (reset) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (aux_req && !proc_ram_s) begin
                        aux_gnt_s = 1'b1;
                        if (aux_wren) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_AUX_RD;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_AUX_RD: begin
                    // RAM data for the granted aux read is on ram_dataOut now; no new grant here.
                    aux_valid_s = 1'b1;
                    state_d     = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // RAM port mux: processor first, then a granted aux request, otherwise no write.
    always_comb begin
        ram_wEn    = 1'b0;
        ram_addr   = proc_addr[11:0];
        ram_dataIn = proc_data;
        if (reset) begin
            ram_wEn = 1'b0;
        end else if (proc_ram_s) begin
            ram_wEn    = proc_wren;
            ram_addr   = proc_addr[11:0];
            ram_dataIn = proc_data;
        end else if (aux_gnt_s) begin
            ram_wEn    = aux_wren;
            ram_addr   = aux_addr;
            ram_dataIn = aux_data;
        end else begin
            ram_wEn = 1'b0;
        end
    end

    // Button read flag next state: set when the processor reads the button register.
    always_comb begin
        btn_rd_d = 1'b0;
        if (proc_rd && (proc_addr == BUTTON_ADDR)) begin
            btn_rd_d = 1'b1;
        end else begin
            btn_rd_d = 1'b0;
        end
    end

    // Debounce next state: the output flips only after CNT_MAX+1 consecutive differing samples.
    always_comb begin
        cnt_d    = cnt_q;
        btn_db_d = btn_db_q;
        if (sync2_q == btn_db_q) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (cnt_q == CNT_MAX) begin
            cnt_d    = {CNT_W{1'b0}};
            btn_db_d = ~btn_db_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State, button-read bookkeeping, synchronizer and debounce registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            btn_rd_q  <= 1'b0;
            btn_val_q <= 1'b0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            btn_db_q  <= 1'b0;
            cnt_q     <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            btn_rd_q  <= btn_rd_d;
            btn_val_q <= btn_db_q;
            sync1_q   <= button_in;
            sync2_q   <= sync1_q;
            btn_db_q  <= btn_db_d;
            cnt_q     <= cnt_d;
        end
    end

    // Read data returns one cycle after the access, matching the RAM's read latency.
    assign proc_q    = btn_rd_q ? {31'd0, btn_val_q} : ram_dataOut;
    assign aux_gnt   = aux_gnt_s;
    assign aux_valid = aux_valid_s;
    assign aux_q     = aux_valid_s ? ram_dataOut : 32'd0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 1-cycle RAM and a scoreboard of read results.
module tb_dmem_arbiter;

    localparam logic [31:0] BTN = 32'd1000;

    logic        clock = 1'b0;
    logic        reset;
    logic        proc_wren, proc_rd;
    logic [31:0] proc_addr, proc_data, proc_q;
    logic        aux_req, aux_wren;
    logic [11:0] aux_addr;
    logic [31:0] aux_data, aux_q;
    logic        aux_gnt, aux_valid;
    logic        button_in;
    logic        ram_wEn;
    logic [11:0] ram_addr;
    logic [31:0] ram_dataIn, ram_dataOut;

    logic [31:0] mem [0:4095];

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] proc_sb[$];
    logic [31:0] aux_sb[$];
    bit          proc_due = 1'b0;
    bit          aux_due  = 1'b0;

    dmem_arbiter #(.BUTTON_ADDR(BTN), .DEBOUNCE_CYCLES(16)) dut (
        .clock(clock), .reset(reset),
        .proc_wren(proc_wren), .proc_rd(proc_rd), .proc_addr(proc_addr),
        .proc_data(proc_data), .proc_q(proc_q),
        .aux_req(aux_req), .aux_wren(aux_wren), .aux_addr(aux_addr), .aux_data(aux_data),
        .aux_gnt(aux_gnt), .aux_valid(aux_valid), .aux_q(aux_q),
        .button_in(button_in),
        .ram_wEn(ram_wEn), .ram_addr(ram_addr), .ram_dataIn(ram_dataIn),
        .ram_dataOut(ram_dataOut)
    );

    always #5 clock = ~clock;

    // Single-port RAM with synchronous read (old data on same-cycle write).
    always @(posedge clock) begin
        if (ram_wEn) mem[ram_addr] <= ram_dataIn;
        ram_dataOut <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        proc_wren = 1'b0;
        proc_rd   = 1'b0;
        aux_req   = 1'b0;
        aux_wren  = 1'b0;
    endtask

    task automatic push_proc(input logic [31:0] v);
        proc_sb.push_back(v);
        proc_due = 1'b1;
    endtask

    task automatic push_aux(input logic [31:0] v);
        aux_sb.push_back(v);
        aux_due = 1'b1;
    endtask

    // Advance one clock and compare the registered-latency outputs against the scoreboard.
    task automatic end_cycle();
        @(posedge clock);
        #1;
        check("aux_valid", 32'(aux_valid), 32'(aux_due));
        if (aux_due) check("aux_q", aux_q, aux_sb.pop_front());
        else         check("aux_q_idle", aux_q, 32'd0);
        if (proc_due) check("proc_q", proc_q, proc_sb.pop_front());
        aux_due  = 1'b0;
        proc_due = 1'b0;
    endtask

    initial begin
        // reset with conflicting requests present: nothing may reach the RAM or aux
        reset     = 1'b1;
        button_in = 1'b0;
        proc_wren = 1'b1; proc_rd = 1'b0; proc_addr = 32'd5; proc_data = 32'h1234;
        aux_req   = 1'b1; aux_wren = 1'b0; aux_addr = 12'd9; aux_data = 32'd0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_aux_gnt", 32'(aux_gnt), 32'd0);
        check("rst_ram_wEn", 32'(ram_wEn), 32'd0);
        check("rst_aux_valid", 32'(aux_valid), 32'd0);
        check("rst_aux_q", aux_q, 32'd0);
        idle_inputs();
        reset = 1'b0;
        end_cycle();

        // processor sw 5 <- 0xA5, then lw 5
        proc_wren = 1'b1; proc_addr = 32'd5; proc_data = 32'hA5;
        #1;
        check("sw_ram_wEn", 32'(ram_wEn), 32'd1);
        check("sw_ram_addr", 32'(ram_addr), 32'd5);
        check("sw_ram_dataIn", ram_dataIn, 32'hA5);
        end_cycle();
        idle_inputs();
        proc_rd = 1'b1; proc_addr = 32'd5; push_proc(32'hA5);
        #1;
        check("lw_ram_wEn", 32'(ram_wEn), 32'd0);
        end_cycle();

        // aux read while the processor is idle; processor lw in the AUX_RD cycle
        idle_inputs();
        aux_req = 1'b1; aux_wren = 1'b0; aux_addr = 12'd5;
        #1;
        check("aux_gnt_idle", 32'(aux_gnt), 32'd1);
        check("aux_rd_addr", 32'(ram_addr), 32'd5);
        check("aux_rd_wEn", 32'(ram_wEn), 32'd0);
        push_aux(32'hA5);
        end_cycle();
        check("aux_gnt_in_auxrd", 32'(aux_gnt), 32'd0);
        aux_req = 1'b0;
        proc_rd = 1'b1; proc_addr = 32'd5; push_proc(32'hA5);
        #1;
        check("proc_in_auxrd_addr", 32'(ram_addr), 32'd5);
        end_cycle();
        idle_inputs();
        #1;
        end_cycle();

        // aux read held through three processor lw cycles
        aux_req = 1'b1; aux_wren = 1'b0; aux_addr = 12'd5;
        for (int i = 0; i < 3; i++) begin
            proc_rd = 1'b1; proc_addr = 32'd5; push_proc(32'hA5);
            #1;
            check("aux_gnt_blocked", 32'(aux_gnt), 32'd0);
            end_cycle();
        end
        proc_rd = 1'b0;
        #1;
        check("aux_gnt_after_proc", 32'(aux_gnt), 32'd1);
        push_aux(32'hA5);
        end_cycle();
        aux_req = 1'b0;
        #1;
        end_cycle();

        // processor sw to the button alone never writes the RAM
        proc_wren = 1'b1; proc_addr = BTN; proc_data = 32'hFFFF_FFFF;
        #1;
        check("btn_sw_wEn", 32'(ram_wEn), 32'd0);
        // concurrent aux write to addr 7 takes the free RAM
        aux_req = 1'b1; aux_wren = 1'b1; aux_addr = 12'd7; aux_data = 32'h3C;
        #1;
        check("btn_sw_aux_gnt", 32'(aux_gnt), 32'd1);
        check("btn_sw_aux_wEn", 32'(ram_wEn), 32'd1);
        check("btn_sw_aux_addr", 32'(ram_addr), 32'd7);
        check("btn_sw_aux_data", ram_dataIn, 32'h3C);
        end_cycle();
        idle_inputs();
        proc_rd = 1'b1; proc_addr = 32'd7; push_proc(32'h3C);
        end_cycle();

        // button held 20 cycles debounces to 1
        idle_inputs();
        button_in = 1'b1;
        repeat (20) end_cycle();
        proc_rd = 1'b1; proc_addr = BTN; push_proc(32'd1);
        #1;
        check("btn_lw_wEn", 32'(ram_wEn), 32'd0);
        end_cycle();
        // a RAM read right after the button read returns RAM data again
        proc_addr = 32'd5; push_proc(32'hA5);
        end_cycle();
        proc_rd = 1'b0;
        button_in = 1'b0;
        repeat (20) end_cycle();
        proc_rd = 1'b1; proc_addr = BTN; push_proc(32'd0);
        end_cycle();
        proc_rd = 1'b0;

        // 10-cycle glitch never reaches the debounced value
        button_in = 1'b1;
        repeat (10) end_cycle();
        button_in = 1'b0;
        proc_rd = 1'b1; proc_addr = BTN; push_proc(32'd0);
        end_cycle();
        proc_rd = 1'b0;
        repeat (20) end_cycle();
        proc_rd = 1'b1; proc_addr = BTN; push_proc(32'd0);
        end_cycle();

        // reset during AUX_RD discards the pending aux read
        idle_inputs();
        aux_req = 1'b1; aux_wren = 1'b0; aux_addr = 12'd5;
        #1;
        check("pre_rst_aux_gnt", 32'(aux_gnt), 32'd1);
        @(posedge clock);
        #1;
        reset   = 1'b1;
        aux_req = 1'b0;
        #1;
        check("auxrd_rst_valid", 32'(aux_valid), 32'd0);
        check("auxrd_rst_q", aux_q, 32'd0);
        check("auxrd_rst_gnt", 32'(aux_gnt), 32'd0);
        check("auxrd_rst_wEn", 32'(ram_wEn), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("post_rst_valid", 32'(aux_valid), 32'd0);
        check("post_rst_q", aux_q, 32'd0);
        check("post_rst_wEn", 32'(ram_wEn), 32'd0);
        end_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter BUTTON_ADDR, default 32'd1000, the processor word address decoded as the button register.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16, the number of stable cycles required before the debounced button changes.
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous and active-high.
REQ-005 SHALL have ports proc_wren (input, 1), proc_rd (input, 1), proc_addr (input, 32) and proc_data (input, 32), which form the processor dmem request.
REQ-006 SHALL have port proc_q, output, 32, the processor read data.
REQ-007 SHALL have ports aux_req (input, 1), aux_wren (input, 1), aux_addr (input, 12) and aux_data (input, 32), which form the secondary requester (display/game logic).
REQ-008 SHALL have ports aux_gnt (output, 1), aux_valid (output, 1) and aux_q (output, 32).
REQ-009 SHALL have port button_in, input, 1, the raw asynchronous button.
REQ-010 SHALL have ports ram_wEn (output, 1), ram_addr (output, 12) and ram_dataIn (output, 32), plus ram_dataOut (input, 32), which connect to a single-port RAM with a 1-cycle synchronous read.

Function
REQ-011 SHALL define a processor access as proc_wren|proc_rd in the current cycle; a button access is a processor access with proc_addr==BUTTON_ADDR.
REQ-012 SHALL give the processor absolute priority: a processor access to any address other than BUTTON_ADDR drives ram_wEn=proc_wren, ram_addr=proc_addr[11:0] and ram_dataIn=proc_data combinationally in the same cycle.
REQ-013 SHALL NOT let a processor write to BUTTON_ADDR reach the RAM (ram_wEn=0); the write is ignored.
REQ-014 SHALL grant aux in any cycle where aux_req=1, no non-button processor access is present and the FSM is not in AUX_RD: aux_gnt=1 for exactly that cycle, and the RAM is driven from the aux_* ports.
REQ-015 SHALL require aux to hold aux_req, aux_addr, aux_wren and aux_data stable until aux_gnt; the wait is unbounded while the processor occupies the RAM.
REQ-016 SHALL implement an FSM with states IDLE and AUX_RD: IDLE->AUX_RD on a granted aux read; AUX_RD->IDLE unconditionally after one cycle; a granted aux write stays in IDLE.
REQ-017 SHALL, in AUX_RD, assert aux_valid=1 for exactly one cycle with aux_q=ram_dataOut, and grant no new aux request in that cycle; a processor access in that cycle still proceeds.
REQ-018 SHALL match RAM latency for the processor: a registered flag records whether the previous cycle was a button read; proc_q={31'b0,btn_db} captured at access time if the flag is set, else proc_q=ram_dataOut.
REQ-019 SHALL pass button_in through a 2-flop synchronizer, then a debounce counter: the counter resets whenever the synchronized value equals btn_db, increments otherwise, and btn_db toggles and the counter clears when it reaches DEBOUNCE_CYCLES-1.
REQ-020 SHALL size the debounce counter to ceil(log2(DEBOUNCE_CYCLES)) bits with no wrap; a glitch shorter than DEBOUNCE_CYCLES cycles never changes btn_db.
REQ-021 SHALL, when aux_req and a non-button processor access occur in the same cycle, serve only the processor, with aux_gnt=0.
REQ-022 SHALL allow aux to use the RAM when the processor accesses BUTTON_ADDR, since the RAM is free in that cycle.

Reset
REQ-023 SHALL, while reset=1, force FSM=IDLE, aux_gnt=0, aux_valid=0, aux_q=0, the button flag=0, btn_db=0, the synchronizer=0, the counter=0 and ram_wEn=0.
REQ-024 SHALL discard an aux read in flight (AUX_RD) on reset, so that no aux_valid pulse follows reset.

Verification
REQ-025 SHALL be verified by: proc sw addr 5 data 0xA5, then lw addr 5 -> ram_wEn=1 in the sw cycle; proc_q=0xA5 one cycle after the lw.
REQ-026 SHALL be verified by: aux_req read addr 5 while the processor is idle -> aux_gnt the same cycle; aux_valid=1 with aux_q=0xA5 on the next cycle only.
REQ-027 SHALL be verified by: aux_req held during 3 consecutive processor lw cycles -> aux_gnt=0 for 3 cycles, then 1 in the first idle cycle.
REQ-028 SHALL be verified by: button_in=1 held for 20 cycles, then proc lw BUTTON_ADDR -> proc_q=1; a 10-cycle pulse -> proc_q stays 0.
REQ-029 SHALL be verified by: proc sw BUTTON_ADDR concurrent with aux write addr 7 data 0x3C -> the RAM receives only the aux write; a later lw addr 7 returns 0x3C.
REQ-030 SHALL be verified by: reset asserted in the AUX_RD cycle -> aux_valid=0 and all outputs at reset values on the following cycle.
